// File: rtl/ifetch_unit.sv
// Instruction fetch stage: PC/IR, req/ack fetch from instruction memory, next-PC logic.
// Ports: clk/rst_n; im_req/im_addr/im_ack/im_rdata (imem); npc_op/zero/rs_data/pc_wr (control);
//        instr/op/funct/pc/pc_plus4/instr_valid/align_err (to decoder and write-back).
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        im_req,
    output logic [31:0] im_addr,
    input  logic        im_ack,
    input  logic [31:0] im_rdata,
    input  logic [1:0]  npc_op,
    input  logic        zero,
    input  logic [31:0] rs_data,
    input  logic        pc_wr,
    output logic [31:0] instr,
    output logic [5:0]  op,
    output logic [5:0]  funct,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        instr_valid,
    output logic        align_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_EXEC
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic        r_align_err;

    logic        w_ld_ir;
    logic        w_upd_pc;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_br_off;
    logic [31:0] w_npc;
    logic        w_align_bad;

    assign w_pc_plus4  = r_pc + 32'd4;
    assign w_br_off    = {{14{r_instr[15]}}, r_instr[15:0], 2'b00};
    assign w_align_bad = (npc_op == 2'b11) && (rs_data[1:0] != 2'b00);

    always_comb begin
        w_npc = w_pc_plus4;
        unique case (npc_op)
            2'b00: w_npc = w_pc_plus4;
            2'b01: w_npc = zero ? (w_pc_plus4 + w_br_off) : w_pc_plus4;
            2'b10: w_npc = {w_pc_plus4[31:28], r_instr[25:0], 2'b00};
            2'b11: w_npc = {rs_data[31:2], 2'b00};
            default: w_npc = w_pc_plus4;
        endcase
    end

    // Outputs decode straight from the state register so that an
    // asynchronous reset drops im_req in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_ld_ir     = 1'b0;
        w_upd_pc    = 1'b0;
        im_req      = 1'b0;
        instr_valid = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_state_nxt = S_REQ;
            end
            S_REQ: begin
                im_req = 1'b1;
                if (im_ack) begin
                    w_ld_ir     = 1'b1;
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                instr_valid = 1'b1;
                if (pc_wr) begin
                    w_upd_pc    = 1'b1;
                    w_state_nxt = S_REQ;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_pc        <= RESET_PC;
            r_instr     <= 32'd0;
            r_align_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_align_err <= w_upd_pc && w_align_bad;
            if (w_ld_ir) begin
                r_instr <= im_rdata;
            end
            if (w_upd_pc) begin
                r_pc <= w_npc;
            end
        end
    end

    assign im_addr   = r_pc;
    assign pc        = r_pc;
    assign pc_plus4  = w_pc_plus4;
    assign instr     = r_instr;
    assign op        = r_instr[31:26];
    assign funct     = r_instr[5:0];
    assign align_err = r_align_err;

endmodule

// File: tb/tb_ifetch_unit.sv
// Testbench for ifetch_unit: directed instruction stream with a commit scoreboard.
// Stimulus pushes expected commit records; a monitor pops them on each PC update.
module tb_ifetch_unit;

    logic        clk;
    logic        rst_n;
    logic        im_req;
    logic [31:0] im_addr;
    logic        im_ack;
    logic [31:0] im_rdata;
    logic [1:0]  npc_op;
    logic        zero;
    logic [31:0] rs_data;
    logic        pc_wr;
    logic [31:0] instr;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        instr_valid;
    logic        align_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [5:0]  op;
        logic [5:0]  funct;
        logic [31:0] pp4;
    } exp_t;

    exp_t sb[$];

    ifetch_unit #(.RESET_PC(32'h0000_3000)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .im_req     (im_req),
        .im_addr    (im_addr),
        .im_ack     (im_ack),
        .im_rdata   (im_rdata),
        .npc_op     (npc_op),
        .zero       (zero),
        .rs_data    (rs_data),
        .pc_wr      (pc_wr),
        .instr      (instr),
        .op         (op),
        .funct      (funct),
        .pc         (pc),
        .pc_plus4   (pc_plus4),
        .instr_valid(instr_valid),
        .align_err  (align_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Monitor: a commit is a cycle in EXEC with pc_wr high.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && instr_valid && pc_wr) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_empty: commit at pc %h with no expected record", pc);
                end else begin
                    e = sb.pop_front();
                    chk("commit_pc", pc, e.pc);
                    chk("commit_instr", instr, e.instr);
                    chk("commit_op", {26'd0, op}, {26'd0, e.op});
                    chk("commit_funct", {26'd0, funct}, {26'd0, e.funct});
                    chk("commit_pc_plus4", pc_plus4, e.pp4);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic wait_req();
        int n;
        n = 0;
        while (!im_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("req_seen", {31'd0, im_req}, 32'd1);
    endtask

    task automatic run_instr(
        input logic [31:0] rdata,
        input int          delay,
        input logic [1:0]  nop,
        input logic        z,
        input logic [31:0] rs,
        input int          stall,
        input logic [31:0] exp_pc,
        input logic [5:0]  exp_op,
        input logic [5:0]  exp_funct,
        input logic [31:0] exp_pp4,
        input logic [31:0] exp_npc,
        input logic        exp_align
    );
        exp_t e;
        wait_req();
        chk("fetch_addr", im_addr, exp_pc);
        e.pc    = exp_pc;
        e.instr = rdata;
        e.op    = exp_op;
        e.funct = exp_funct;
        e.pp4   = exp_pp4;
        sb.push_back(e);
        im_ack   = 1'b0;
        im_rdata = 32'hBAD0_BAD0;
        for (int d = 0; d < delay; d++) begin
            @(negedge clk);
            chk("wait_req", {31'd0, im_req}, 32'd1);
            chk("wait_addr", im_addr, exp_pc);
        end
        im_ack   = 1'b1;
        im_rdata = rdata;
        @(negedge clk);
        im_ack   = 1'b0;
        chk("exec_valid", {31'd0, instr_valid}, 32'd1);
        chk("exec_req", {31'd0, im_req}, 32'd0);
        npc_op  = nop;
        zero    = z;
        rs_data = rs;
        pc_wr   = 1'b0;
        for (int s = 0; s < stall; s++) begin
            im_ack   = 1'b1;
            im_rdata = 32'hDEAD_BEEF;
            @(negedge clk);
            chk("stall_pc", pc, exp_pc);
            chk("stall_instr", instr, rdata);
            chk("stall_req", {31'd0, im_req}, 32'd0);
        end
        im_ack = 1'b0;
        pc_wr  = 1'b1;
        @(negedge clk);
        pc_wr = 1'b0;
        chk("next_pc", pc, exp_npc);
        chk("align_pulse", {31'd0, align_err}, {31'd0, exp_align});
        @(negedge clk);
        chk("align_clear", {31'd0, align_err}, 32'd0);
    endtask

    initial begin
        rst_n    = 1'b0;
        im_ack   = 1'b0;
        im_rdata = 32'd0;
        npc_op   = 2'b00;
        zero     = 1'b0;
        rs_data  = 32'd0;
        pc_wr    = 1'b0;
        #12;
        chk("rst_pc", pc, 32'h0000_3000);
        chk("rst_instr", instr, 32'd0);
        chk("rst_req", {31'd0, im_req}, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_align", {31'd0, align_err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // addu, 3-cycle ack delay
        run_instr(32'h0232_8021, 3, 2'b00, 1'b0, 32'd0, 0,
                  32'h3000, 6'h00, 6'h21, 32'h3004, 32'h3004, 1'b0);
        // ori, sequential
        run_instr(32'h3408_0005, 0, 2'b00, 1'b0, 32'd0, 0,
                  32'h3004, 6'h0D, 6'h05, 32'h3008, 32'h3008, 1'b0);
        // beq -1 taken: loops on itself
        run_instr(32'h1000_FFFF, 1, 2'b01, 1'b1, 32'd0, 0,
                  32'h3008, 6'h04, 6'h3F, 32'h300C, 32'h3008, 1'b0);
        // beq -1 not taken
        run_instr(32'h1000_FFFF, 0, 2'b01, 1'b0, 32'd0, 0,
                  32'h3008, 6'h04, 6'h3F, 32'h300C, 32'h300C, 1'b0);
        // lw with 4 stall cycles and stray acks
        run_instr(32'h8C09_0000, 0, 2'b00, 1'b0, 32'd0, 4,
                  32'h300C, 6'h23, 6'h00, 32'h3010, 32'h3010, 1'b0);
        // jal 0x0C05
        run_instr(32'h0C00_0C05, 0, 2'b10, 1'b0, 32'd0, 0,
                  32'h3010, 6'h03, 6'h05, 32'h3014, 32'h3014, 1'b0);
        // jr misaligned
        run_instr(32'h03E0_0008, 0, 2'b11, 1'b0, 32'h0000_3023, 0,
                  32'h3014, 6'h00, 6'h08, 32'h3018, 32'h3020, 1'b1);
        // jr to top of address space
        run_instr(32'h03E0_0008, 2, 2'b11, 1'b0, 32'hFFFF_FFFC, 0,
                  32'h3020, 6'h00, 6'h08, 32'h3024, 32'hFFFF_FFFC, 1'b0);
        // sequential wrap to 0
        run_instr(32'h0000_0000, 0, 2'b00, 1'b0, 32'd0, 0,
                  32'hFFFF_FFFC, 6'h00, 6'h00, 32'h0000_0000, 32'h0000_0000, 1'b0);
        // beq -2 taken from 0 wraps below zero
        run_instr(32'h1000_FFFE, 0, 2'b01, 1'b1, 32'd0, 0,
                  32'h0000_0000, 6'h04, 6'h3E, 32'h0000_0004, 32'hFFFF_FFFC, 1'b0);

        // Reset mid-fetch with an ack pending
        wait_req();
        chk("mid_addr", im_addr, 32'hFFFF_FFFC);
        @(negedge clk);
        im_ack   = 1'b1;
        im_rdata = 32'h1234_5678;
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_req", {31'd0, im_req}, 32'd0);
        chk("arst_valid", {31'd0, instr_valid}, 32'd0);
        chk("arst_pc", pc, 32'h0000_3000);
        chk("arst_instr", instr, 32'd0);

        // Release with ack held high
        im_rdata = 32'h0232_8021;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_c1_req", {31'd0, im_req}, 32'd0);
        @(negedge clk);
        chk("rel_c2_req", {31'd0, im_req}, 32'd1);
        chk("rel_c2_addr", im_addr, 32'h0000_3000);
        sb.push_back('{32'h3000, 32'h0232_8021, 6'h00, 6'h21, 32'h3004});
        @(negedge clk);
        im_ack = 1'b0;
        chk("rel_c3_valid", {31'd0, instr_valid}, 32'd1);
        chk("rel_c3_instr", instr, 32'h0232_8021);
        npc_op = 2'b00;
        pc_wr  = 1'b1;
        @(negedge clk);
        pc_wr = 1'b0;
        chk("rel_next_pc", pc, 32'h0000_3004);
        @(negedge clk);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_left: got %0d pending expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
